// File: rtl/ide_arbiter.sv
// rtl/ide_arbiter.sv - round-robin owner arbiter sharing one IDE transaction port between two clients
// An owner keeps the port for a whole command sequence; a watchdog reclaims it from a stalled owner.
module ide_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_lock,
  input  logic        m0_rd,
  input  logic        m0_wr,
  input  logic [4:0]  m0_addr,
  input  logic [15:0] m0_in,
  output logic [15:0] m0_out,
  output logic        m0_done,
  input  logic        m1_lock,
  input  logic        m1_rd,
  input  logic        m1_wr,
  input  logic [4:0]  m1_addr,
  input  logic [15:0] m1_in,
  output logic [15:0] m1_out,
  output logic        m1_done,
  output logic [1:0]  grant,
  output logic [1:0]  timeout_err,
  output logic        ata_rd,
  output logic        ata_wr,
  output logic [4:0]  ata_addr,
  output logic [15:0] ata_in,
  input  logic [15:0] ata_out,
  input  logic        ata_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  terr_q, terr_d;
  logic        req0, req1, wd_hit;

  assign req0   = m0_lock | m0_rd | m0_wr;
  assign req1   = m1_lock | m1_rd | m1_wr;
  assign wd_hit = (TIMEOUT != 16'd0) && (cnt_q == TIMEOUT) && !ata_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 16'd0;
      terr_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    terr_d  = 2'b00;
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        // last_q == 1 means client 1 was served most recently, so client 0 wins a tie
        if (req0 && (!req1 || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0: begin
        cnt_d = ata_done ? 16'd0 : cnt_q + 16'd1;
        if (wd_hit) begin
          state_d = IDLE;
          terr_d  = 2'b01;
          cnt_d   = 16'd0;
        end else if (!req0) begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        cnt_d = ata_done ? 16'd0 : cnt_q + 16'd1;
        if (wd_hit) begin
          state_d = IDLE;
          terr_d  = 2'b10;
          cnt_d   = 16'd0;
        end else if (!req1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant       = 2'b00;
    timeout_err = terr_q;
    ata_rd      = 1'b0;
    ata_wr      = 1'b0;
    ata_addr    = 5'd0;
    ata_in      = 16'd0;
    m0_out      = 16'd0;
    m0_done     = 1'b0;
    m1_out      = 16'd0;
    m1_done     = 1'b0;
    case (state_q)
      OWN0: begin
        grant    = 2'b01;
        ata_rd   = m0_rd;
        ata_wr   = m0_wr & ~m0_rd;
        ata_addr = m0_addr;
        ata_in   = m0_in;
        m0_out   = ata_out;
        m0_done  = ata_done;
      end
      OWN1: begin
        grant    = 2'b10;
        ata_rd   = m1_rd;
        ata_wr   = m1_wr & ~m1_rd;
        ata_addr = m1_addr;
        ata_in   = m1_in;
        m1_out   = ata_out;
        m1_done  = ata_done;
      end
      default: ;
    endcase
  end

endmodule
